uart_fifo: RTL

UART_FIFO -- requirements
Module: uart_fifo

---
 rtl/uart_fifo.sv | 121 ++++++++++++
 1 files changed

// File: rtl/uart_fifo.sv
// Single-clock synchronous FIFO for UART data paths with occupancy flags and sticky error bits.
// Define UART_FIFO_FWFT_EN to build first-word-fall-through mode; standard registered-read mode otherwise.
module uart_fifo #(
  parameter int DATA_BIT = 8,
  parameter int ADDR_BIT = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [DATA_BIT-1:0] wr_data,
  input  logic                rd_en,
  output logic [DATA_BIT-1:0] rd_data,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDR_BIT:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int                DEPTH   = 1 << ADDR_BIT;
  localparam logic [ADDR_BIT:0] DEPTH_C = (ADDR_BIT + 1)'(DEPTH);
  localparam logic [ADDR_BIT:0] AF_C    = (ADDR_BIT + 1)'(AF_LEVEL);
  localparam logic [ADDR_BIT:0] AE_C    = (ADDR_BIT + 1)'(AE_LEVEL);
  localparam logic [ADDR_BIT:0] CNT_ONE = (ADDR_BIT + 1)'(1);
  localparam logic [ADDR_BIT-1:0] PTR_ONE = ADDR_BIT'(1);

  logic [DATA_BIT-1:0] mem [DEPTH];
  logic [ADDR_BIT-1:0] wr_ptr;
  logic [ADDR_BIT-1:0] rd_ptr;
  logic [ADDR_BIT:0]   count_q;

  logic wr_accept;  // word enters the RAM this edge
  logic pop;        // word leaves the FIFO (count decrements) this edge
  logic ram_rd;     // RAM head is read into rd_data this edge

  // Flags come straight from the registered count.
  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign wr_accept    = wr_en && !full;

`ifdef UART_FIFO_FWFT_EN
  // count includes the word sitting in the output stage; ram_cnt excludes it.
  logic              out_valid;
  logic [ADDR_BIT:0] ram_cnt;

  assign ram_cnt = count_q - {{ADDR_BIT{1'b0}}, out_valid};
  assign empty   = !out_valid;
  assign pop     = rd_en && out_valid;
  assign ram_rd  = (ram_cnt != '0) && (!out_valid || pop);
`else
  assign empty   = (count_q == '0);
  assign pop     = rd_en && !empty;
  assign ram_rd  = pop;
`endif

  // NOTE: the storage array has no reset so it maps onto block RAM; only control state is reset.
  always_ff @(posedge clk) begin
    if (wr_accept && !clr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      rd_data   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
`ifdef UART_FIFO_FWFT_EN
      out_valid <= 1'b0;
`endif
    end else if (clr) begin
      // Flush wins over any simultaneous request; rd_data keeps its last value.
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
`ifdef UART_FIFO_FWFT_EN
      out_valid <= 1'b0;
`endif
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (ram_rd) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        rd_data <= mem[rd_ptr];
      end
      case ({wr_accept, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
`ifdef UART_FIFO_FWFT_EN
      if (ram_rd) begin
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
`endif
    end
  end

endmodule
